// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared types and default constants for the button event decoder.
//   state_e            : decoder FSM states (LOCKOUT is the reset state)
//   DEF_LONG_CYCLES    : long-press threshold, 0.5 s at 50 MHz
//   DEF_REPEAT_CYCLES  : auto-repeat period, 0.1 s at 50 MHz
//   DEF_CNT_W          : counter width able to hold max(long, repeat) - 1
// -----------------------------------------------------------------------------
package button_event_pkg;

   typedef enum logic [1:0] {
      ST_LOCKOUT = 2'd0,
      ST_IDLE    = 2'd1,
      ST_SHORT   = 2'd2,
      ST_LONG    = 2'd3
   } state_e;

   localparam int DEF_LONG_CYCLES   = 25_000_000;
   localparam int DEF_REPEAT_CYCLES = 5_000_000;
   localparam int DEF_CNT_W         = 25;

endpackage

// File: rtl/button_event_timer.sv
// -----------------------------------------------------------------------------
// button_event_timer
// Loadable up-counter with clear, enable and terminal-match output.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset (count -> 0)
//   clr_i        in   count -> 0 (highest priority after reset)
//   load_i       in   count -> load_val_i
//   load_val_i   in   value loaded by load_i
//   en_i         in   count -> count + 1
//   match_val_i  in   terminal value compared against the current count
//   cnt_o        out  current count
//   match_o      out  1 when the current count equals match_val_i
// The owner guarantees clr_i is asserted at the terminal value, so the count
// never wraps.
// -----------------------------------------------------------------------------
module button_event_timer #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] match_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             match_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign match_o = (cnt_q == match_val_i);

endmodule

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
// Turns a debounced pushbutton level into single-cycle event pulses.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN (auto-repeat in LONG state;
// when undefined repeat_pulse is constant 0 and the counter idles in LONG).
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   pb_state       in   debounced level, 1 = pressed
//   press_pulse    out  one cycle on accepted press
//   click_pulse    out  one cycle on release before the long threshold
//   long_pulse     out  one cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   out  one cycle every REPEAT_CYCLES after long_pulse
//   release_pulse  out  one cycle on any release after an accepted press
//   held           out  level, 1 while in SHORT or LONG
// All outputs are registered and clear to 0 in reset.
// -----------------------------------------------------------------------------
module button_event
   import button_event_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_state,
   output logic press_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic release_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_e state_q, state_d;
   logic   press_q,   press_d;
   logic   click_q,   click_d;
   logic   long_q,    long_d;
   logic   release_q, release_d;
   logic   held_q,    held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
   logic   repeat_q,  repeat_d;
`endif

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_match;
   logic [CNT_W-1:0] cnt_match_val;
   logic [CNT_W-1:0] cnt_val;

   // The terminal value depends only on the current state: the long
   // threshold while in SHORT, the repeat period while in LONG.
   assign cnt_match_val = (state_q == ST_LONG) ? REPEAT_LAST : LONG_LAST;

   button_event_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (cnt_clr),
      .load_i      (1'b0),
      .load_val_i  ('0),
      .en_i        (cnt_en),
      .match_val_i (cnt_match_val),
      .cnt_o       (cnt_val),
      .match_o     (cnt_match)
   );

   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      click_d   = 1'b0;
      long_d    = 1'b0;
      release_d = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_d  = 1'b0;
`endif
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         // Wait for the button to be seen released after reset so a button
         // held through reset never produces a press.
         ST_LOCKOUT: begin
            if (!pb_state) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (pb_state) begin
               press_d = 1'b1;
               cnt_clr = 1'b1;
               state_d = ST_SHORT;
            end
         end
         // Release wins over the threshold match on the same edge.
         ST_SHORT: begin
            if (!pb_state) begin
               click_d   = 1'b1;
               release_d = 1'b1;
               cnt_clr   = 1'b1;
               state_d   = ST_IDLE;
            end else if (cnt_match) begin
               long_d  = 1'b1;
               cnt_clr = 1'b1;
               state_d = ST_LONG;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_LONG: begin
            if (!pb_state) begin
               release_d = 1'b1;
               cnt_clr   = 1'b1;
               state_d   = ST_IDLE;
            end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
               if (cnt_match) begin
                  repeat_d = 1'b1;
                  cnt_clr  = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
`endif
            end
         end
         default: begin
            state_d = ST_LOCKOUT;
         end
      endcase

      held_d = (state_d == ST_SHORT) || (state_d == ST_LONG);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_LOCKOUT;
         press_q   <= 1'b0;
         click_q   <= 1'b0;
         long_q    <= 1'b0;
         release_q <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         click_q   <= click_d;
         long_q    <= long_d;
         release_q <= release_d;
         held_q    <= held_d;
      end
   end

`ifdef BUTTON_EVENT_REPEAT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= repeat_d;
      end
   end
   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign press_pulse   = press_q;
   assign click_pulse   = click_q;
   assign long_pulse    = long_q;
   assign release_pulse = release_q;
   assign held          = held_q;

   // The count is only observed through the match output.
   logic unused_cnt;
   assign unused_cnt = ^cnt_val;

endmodule
